boundary_scan_register: RTL and testbench

Parametrised boundary-scan register: a chain of `BSR_LEN` data cells plus one output-enable control cell, with shared capture, shift and update controls, all advanced on `internal_clk` when `bsc_tck_enable` is high. It supersedes per-pin cell instantiation and sits between the TAP controller's decoded control strobes and the device pads. It adds four pin modes (functional, extest, clamp, high-Z), a shift-length counter, and optional rejection of truncated scans at update.

---
 rtl/boundary_scan_register.sv | 139 +++++++++++++
 tb/tb_boundary_scan_register.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_scan_register.sv
// Boundary-scan register: BSR_LEN data cells plus one output-enable control cell, with pad mode muxing.
// Latency: scan_in reaches scan_out after BSR_LEN+1 qualified shifts; an update reaches the pads one edge later.
// Backpressure: none; every state change is qualified only by bsc_tck_enable and the TAP strobes.
module boundary_scan_register #(
  parameter int unsigned          BSR_LEN       = 8,
  parameter logic [BSR_LEN-1:0]   BSR_RES_VAL   = '0,
  parameter logic                 CTRL_RES_VAL  = 1'b0,
  parameter logic                 STRICT_UPDATE = 1'b1,
  localparam int unsigned         CNT_W         = $clog2(BSR_LEN + 2) + 1
) (
  input  logic               internal_clk,
  input  logic               bsc_reset_n,
  input  logic               bsc_tck_enable,
  input  logic               bsc_test_logic_reset,
  input  logic               bsc_capture,
  input  logic               bsc_shift_data,
  input  logic               bsc_update,
  input  logic [1:0]         bsc_mode,
  input  logic               bsc_scan_in,
  output logic               bsc_scan_out,
  input  logic [BSR_LEN-1:0] bsr_pin_in,
  input  logic [BSR_LEN-1:0] bsr_core_out,
  input  logic               bsr_core_oe,
  output logic [BSR_LEN-1:0] bsr_pin_out,
  output logic               bsr_pin_oe,
  output logic [CNT_W-1:0]   bsr_shift_cnt,
  output logic               bsr_update_err
);

  typedef enum logic [1:0] {
    MODE_FUNCTIONAL = 2'b00,
    MODE_EXTEST     = 2'b01,
    MODE_CLAMP      = 2'b10,
    MODE_HIGHZ      = 2'b11
  } bsc_mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BSR_LEN + 1);

  logic [BSR_LEN-1:0] shift_dat;
  logic               shift_ctrl;
  logic [BSR_LEN-1:0] hold_dat;
  logic               hold_ctrl;
  logic [CNT_W-1:0]   shift_cnt;
  logic               update_err;

  // Whole chain viewed as one vector: control cell on top, data[0] at the scan_out end.
  logic [BSR_LEN:0]   chain_cur;
  logic [BSR_LEN:0]   chain_shifted;
  logic               update_ok;

  // Chain shift and strict-length qualification of updates (uses the pre-edge count).
  always_comb begin
    chain_cur     = {shift_ctrl, shift_dat};
    chain_shifted = {bsc_scan_in, chain_cur[BSR_LEN:1]};
    update_ok     = !STRICT_UPDATE || (shift_cnt == CNT_FULL);
  end

  // Shift stage: logic reset beats shift, shift beats capture.
  always_ff @(posedge internal_clk) begin
    if (!bsc_reset_n) begin
      shift_dat  <= BSR_RES_VAL;
      shift_ctrl <= CTRL_RES_VAL;
    end else if (bsc_tck_enable) begin
      if (bsc_test_logic_reset) begin
        shift_dat  <= BSR_RES_VAL;
        shift_ctrl <= CTRL_RES_VAL;
      end else if (bsc_shift_data) begin
        {shift_ctrl, shift_dat} <= chain_shifted;
      end else if (bsc_capture) begin
        shift_dat  <= bsr_pin_in;
        shift_ctrl <= bsr_core_oe;
      end
    end
  end

  // Hold stage: takes the pre-edge shift stage on an accepted update.
  always_ff @(posedge internal_clk) begin
    if (!bsc_reset_n) begin
      hold_dat  <= BSR_RES_VAL;
      hold_ctrl <= CTRL_RES_VAL;
    end else if (bsc_tck_enable) begin
      if (bsc_test_logic_reset) begin
        hold_dat  <= BSR_RES_VAL;
        hold_ctrl <= CTRL_RES_VAL;
      end else if (bsc_update && update_ok) begin
        hold_dat  <= shift_dat;
        hold_ctrl <= shift_ctrl;
      end
    end
  end

  // Bits shifted since the last capture; saturates so long scans never wrap back to a valid length.
  always_ff @(posedge internal_clk) begin
    if (!bsc_reset_n) begin
      shift_cnt <= '0;
    end else if (bsc_tck_enable) begin
      if (bsc_test_logic_reset) begin
        shift_cnt <= '0;
      end else if (bsc_shift_data) begin
        if (shift_cnt != CNT_MAX) begin
          shift_cnt <= shift_cnt + CNT_W'(1);
        end
      end else if (bsc_capture) begin
        shift_cnt <= '0;
      end
    end
  end

  // Rejected-update pulse: re-evaluated every edge so it always clears after one cycle.
  always_ff @(posedge internal_clk) begin
    if (!bsc_reset_n) begin
      update_err <= 1'b0;
    end else begin
      update_err <= bsc_tck_enable && !bsc_test_logic_reset && bsc_update && !update_ok;
    end
  end

  // Pad mux: core path in functional mode, hold data otherwise with the mode choosing the enable.
  always_comb begin
    bsr_pin_out = hold_dat;
    bsr_pin_oe  = hold_ctrl;
    case (bsc_mode_e'(bsc_mode))
      MODE_FUNCTIONAL: begin
        bsr_pin_out = bsr_core_out;
        bsr_pin_oe  = bsr_core_oe;
      end
      MODE_EXTEST:     bsr_pin_oe = hold_ctrl;
      MODE_CLAMP:      bsr_pin_oe = 1'b1;
      MODE_HIGHZ:      bsr_pin_oe = 1'b0;
      default:         bsr_pin_oe = 1'b0;
    endcase
  end

  assign bsc_scan_out   = shift_dat[0];
  assign bsr_shift_cnt  = shift_cnt;
  assign bsr_update_err = update_err;

endmodule

// File: tb/tb_boundary_scan_register.sv
// Bench for boundary_scan_register: a strict instance (reset 8'hA5) and a lenient one (reset 8'h00)
// share all inputs and are compared each cycle against a bit-vector reference model,
// plus directed constant checks of reset, shift order, update acceptance, modes and priority.
module tb_boundary_scan_register;

  localparam int N    = 8;
  localparam int CW   = 5;
  localparam int CMAX = 31;

  logic         internal_clk = 1'b0;
  logic         bsc_reset_n, bsc_tck_enable, bsc_test_logic_reset;
  logic         bsc_capture, bsc_shift_data, bsc_update, bsc_scan_in;
  logic [1:0]   bsc_mode;
  logic [N-1:0] bsr_pin_in, bsr_core_out;
  logic         bsr_core_oe;

  logic          so_a, oe_a, err_a, so_b, oe_b, err_b;
  logic [N-1:0]  po_a, po_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int tests = 0;
  int fails = 0;

  // Reference model: chain as a 9-bit vector {ctrl, data[7:0]}, index 0 = scan_out end.
  logic [8:0] m_shift [2];
  logic [8:0] m_hold  [2];
  int         m_cnt   [2];
  logic       m_err   [2];
  logic [8:0] m_res   [2];
  logic       m_strict[2];

  always #5 internal_clk = ~internal_clk;

  boundary_scan_register #(
    .BSR_LEN(8), .BSR_RES_VAL(8'hA5), .CTRL_RES_VAL(1'b0), .STRICT_UPDATE(1'b1)
  ) dut_a (
    .internal_clk(internal_clk), .bsc_reset_n(bsc_reset_n), .bsc_tck_enable(bsc_tck_enable),
    .bsc_test_logic_reset(bsc_test_logic_reset), .bsc_capture(bsc_capture),
    .bsc_shift_data(bsc_shift_data), .bsc_update(bsc_update), .bsc_mode(bsc_mode),
    .bsc_scan_in(bsc_scan_in), .bsc_scan_out(so_a), .bsr_pin_in(bsr_pin_in),
    .bsr_core_out(bsr_core_out), .bsr_core_oe(bsr_core_oe), .bsr_pin_out(po_a),
    .bsr_pin_oe(oe_a), .bsr_shift_cnt(cnt_a), .bsr_update_err(err_a)
  );

  boundary_scan_register #(
    .BSR_LEN(8), .BSR_RES_VAL(8'h00), .CTRL_RES_VAL(1'b0), .STRICT_UPDATE(1'b0)
  ) dut_b (
    .internal_clk(internal_clk), .bsc_reset_n(bsc_reset_n), .bsc_tck_enable(bsc_tck_enable),
    .bsc_test_logic_reset(bsc_test_logic_reset), .bsc_capture(bsc_capture),
    .bsc_shift_data(bsc_shift_data), .bsc_update(bsc_update), .bsc_mode(bsc_mode),
    .bsc_scan_in(bsc_scan_in), .bsc_scan_out(so_b), .bsr_pin_in(bsr_pin_in),
    .bsr_core_out(bsr_core_out), .bsr_core_oe(bsr_core_oe), .bsr_pin_out(po_b),
    .bsr_pin_oe(oe_b), .bsr_shift_cnt(cnt_b), .bsr_update_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the rules for one rising edge to the model, using the current (pre-edge) inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [8:0] os;
      int         oc;
      logic       e;
      os = m_shift[i];
      oc = m_cnt[i];
      e  = 1'b0;
      if (!bsc_reset_n) begin
        m_shift[i] = m_res[i];
        m_hold[i]  = m_res[i];
        m_cnt[i]   = 0;
      end else if (bsc_tck_enable) begin
        if (bsc_test_logic_reset) begin
          m_shift[i] = m_res[i];
          m_hold[i]  = m_res[i];
          m_cnt[i]   = 0;
        end else begin
          if (bsc_shift_data) begin
            m_shift[i] = {bsc_scan_in, os[8:1]};
            m_cnt[i]   = (oc < CMAX) ? oc + 1 : CMAX;
          end else if (bsc_capture) begin
            m_shift[i] = {bsr_core_oe, bsr_pin_in};
            m_cnt[i]   = 0;
          end
          if (bsc_update) begin
            if (!m_strict[i] || oc == N + 1) m_hold[i] = os;
            else e = 1'b1;
          end
        end
      end
      m_err[i] = e;
    end
  endtask

  function automatic logic [8:0] exp_pad(input int i);
    case (bsc_mode)
      2'b00:   return {bsr_core_oe, bsr_core_out};
      2'b01:   return m_hold[i];
      2'b10:   return {1'b1, m_hold[i][7:0]};
      default: return {1'b0, m_hold[i][7:0]};
    endcase
  endfunction

  task automatic check_all();
    chk("model_so_a",  32'(so_a),  32'(m_shift[0][0]));
    chk("model_cnt_a", 32'(cnt_a), m_cnt[0]);
    chk("model_err_a", 32'(err_a), 32'(m_err[0]));
    chk("model_pad_a", 32'({oe_a, po_a}), 32'(exp_pad(0)));
    chk("model_so_b",  32'(so_b),  32'(m_shift[1][0]));
    chk("model_cnt_b", 32'(cnt_b), m_cnt[1]);
    chk("model_err_b", 32'(err_b), 32'(m_err[1]));
    chk("model_pad_b", 32'({oe_b, po_b}), 32'(exp_pad(1)));
  endtask

  // One clock: model advances with the pre-edge inputs, outputs are compared on the falling edge.
  task automatic tick();
    model_step();
    @(posedge internal_clk);
    @(negedge internal_clk);
    check_all();
  endtask

  initial begin
    logic       exp_seq [9];
    logic       exp_oe  [4];
    logic [8:0] vec;
    int         nsh;

    exp_seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_oe  = '{1'b0, 1'b1, 1'b1, 1'b0};
    m_res[0] = 9'h0A5; m_res[1] = 9'h000;
    m_strict[0] = 1'b1; m_strict[1] = 1'b0;

    bsc_reset_n = 1'b0; bsc_tck_enable = 1'b1; bsc_test_logic_reset = 1'b0;
    bsc_capture = 1'b0; bsc_shift_data = 1'b0; bsc_update = 1'b0;
    bsc_mode = 2'b01; bsc_scan_in = 1'b0;
    bsr_pin_in = '0; bsr_core_out = 8'h5A; bsr_core_oe = 1'b0;

    // Reset for two cycles
    tick(); tick();
    chk("rst_scan_out", 32'(so_a), 1);
    chk("rst_cnt",      32'(cnt_a), 0);
    chk("rst_pin_oe",   32'(oe_a), 0);
    chk("rst_pin_out",  32'(po_a), 32'h A5);
    chk("rst_err",      32'(err_a), 0);
    bsc_reset_n = 1'b1;

    // Capture 8'h3C with oe=1, then shift out LSB first, control last
    bsr_pin_in = 8'h3C; bsr_core_oe = 1'b1; bsc_capture = 1'b1;
    tick();
    bsc_capture = 1'b0;
    bsc_shift_data = 1'b1; bsc_scan_in = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("shift_out_seq", 32'(so_a), 32'(exp_seq[k]));
      tick();
    end
    bsc_shift_data = 1'b0;
    chk("shift_cnt_9", 32'(cnt_a), 9);

    // Full-length scan of control=1, data=F0, then update: accepted
    bsc_capture = 1'b1; tick(); bsc_capture = 1'b0;
    vec = 9'h1F0;
    bsc_shift_data = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bsc_scan_in = vec[k];
      tick();
    end
    bsc_shift_data = 1'b0;
    bsc_update = 1'b1; tick(); bsc_update = 1'b0;
    chk("acc_pin_out", 32'(po_a), 32'h F0);
    chk("acc_pin_oe",  32'(oe_a), 1);
    chk("acc_err",     32'(err_a), 0);

    // Truncated scan (7 shifts of 1 after capturing zeros): strict rejects, lenient accepts
    bsr_pin_in = 8'h00; bsr_core_oe = 1'b0; bsc_capture = 1'b1; tick(); bsc_capture = 1'b0;
    bsc_scan_in = 1'b1; bsc_shift_data = 1'b1;
    repeat (7) tick();
    bsc_shift_data = 1'b0;
    bsc_update = 1'b1; tick(); bsc_update = 1'b0;
    chk("rej_pin_out", 32'(po_a), 32'h F0);
    chk("rej_pin_oe",  32'(oe_a), 1);
    chk("rej_err",     32'(err_a), 1);
    chk("lenient_pin_out", 32'(po_b), 32'h FC);
    chk("lenient_pin_oe",  32'(oe_b), 1);
    chk("lenient_err",     32'(err_b), 0);
    tick();
    chk("rej_err_clear", 32'(err_a), 0);

    // Mode sweep with hold control=1, core oe=0
    bsr_core_oe = 1'b0;
    for (int m = 0; m < 4; m++) begin
      bsc_mode = 2'(m);
      #1;
      chk("mode_pin_oe", 32'(oe_a), 32'(exp_oe[m]));
      chk("mode_pin_out", 32'(po_a), (m == 0) ? 32'h 5A : 32'h F0);
    end
    bsc_mode = 2'b01;

    // Enable low: every strobe high yet nothing moves
    bsc_tck_enable = 1'b0;
    bsc_test_logic_reset = 1'b1; bsc_capture = 1'b1; bsc_shift_data = 1'b1; bsc_update = 1'b1;
    tick();
    chk("en0_cnt",      32'(cnt_a), 7);
    chk("en0_scan_out", 32'(so_a), 0);
    chk("en0_pin_out",  32'(po_a), 32'h F0);
    chk("en0_pin_oe",   32'(oe_a), 1);

    // Enable high: test-logic reset wins over shift and update
    bsc_tck_enable = 1'b1; bsc_capture = 1'b0;
    tick();
    bsc_test_logic_reset = 1'b0; bsc_shift_data = 1'b0; bsc_update = 1'b0;
    chk("tlr_cnt",      32'(cnt_a), 0);
    chk("tlr_scan_out", 32'(so_a), 1);
    chk("tlr_pin_out",  32'(po_a), 32'h A5);
    chk("tlr_pin_oe",   32'(oe_a), 0);
    chk("tlr_err",      32'(err_a), 0);

    // Counter saturation
    bsc_shift_data = 1'b1;
    repeat (40) tick();
    chk("cnt_saturate", 32'(cnt_a), CMAX);

    // Reset in the middle of a scan discards it
    bsc_capture = 1'b1; bsc_shift_data = 1'b0; tick(); bsc_capture = 1'b0;
    bsc_shift_data = 1'b1; repeat (3) tick();
    bsc_reset_n = 1'b0; tick();
    bsc_reset_n = 1'b1; bsc_shift_data = 1'b0;
    chk("midscan_cnt",      32'(cnt_a), 0);
    chk("midscan_scan_out", 32'(so_a), 1);

    // Randomized scans of length 8..10 followed by an update
    repeat (30) begin
      bsc_mode = 2'($urandom);
      bsr_pin_in = 8'($urandom); bsr_core_oe = 1'($urandom); bsr_core_out = 8'($urandom);
      bsc_capture = 1'b1; tick(); bsc_capture = 1'b0;
      nsh = $urandom_range(8, 10);
      bsc_shift_data = 1'b1;
      for (int k = 0; k < nsh; k++) begin
        bsc_scan_in = 1'($urandom);
        bsc_update = ($urandom_range(0, 15) == 0);
        tick();
      end
      bsc_shift_data = 1'b0; bsc_update = 1'b1; tick(); bsc_update = 1'b0;
      tick();
    end

    // Fully random strobes and data
    repeat (400) begin
      bsc_reset_n          = ($urandom_range(0, 49) != 0);
      bsc_tck_enable       = ($urandom_range(0, 3) != 0);
      bsc_test_logic_reset = ($urandom_range(0, 29) == 0);
      bsc_capture          = ($urandom_range(0, 5) == 0);
      bsc_shift_data       = 1'($urandom);
      bsc_update           = ($urandom_range(0, 7) == 0);
      bsc_mode             = 2'($urandom);
      bsc_scan_in          = 1'($urandom);
      bsr_pin_in           = 8'($urandom);
      bsr_core_out         = 8'($urandom);
      bsr_core_oe          = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
